perf_counters: RTL and testbench
================================

PERF_COUNTERS -- requirements
Module: perf_counters

Interface
REQ-001 Parameter NUM_CH, default 8, number of event channels (1..32).
REQ-002 Parameter CNT_W, default 32, width of every counter (8..64).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 events  input  NUM_CH  per-channel event strobes.
REQ-006 edge_mode  input  NUM_CH  per channel: 1 = count rising edges; 0 = count asserted cycles.
REQ-007 start  input  1  pulse; begins counting.
REQ-008 stop  input  1  pulse; freezes counting.
REQ-009 clear  input  1  pulse; zeroes counters and returns to IDLE.
REQ-010 snap  input  1  pulse; captures all counters into shadow registers.
REQ-011 rd_sel  input  $clog2(NUM_CH+1)  readout index; the value NUM_CH selects the cycle counter.
REQ-012 rd_data  output  CNT_W  registered readout.
REQ-013 ovf  output  NUM_CH+1  sticky wrap flags; bit NUM_CH belongs to the cycle counter.
REQ-014 state  output  2  current FSM state.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN and FROZEN.
REQ-016 FSM transitions SHALL be: IDLE -start-> RUN; RUN -stop-> FROZEN; FROZEN -start-> RUN (resumes without zeroing); any state -clear-> IDLE.
REQ-017 Input priority SHALL be clear > stop > start; start and stop asserted together in RUN SHALL produce FROZEN, and in IDLE SHALL leave the FSM in IDLE.
REQ-018 Counters SHALL increment only while the state is RUN; an event in cycle N SHALL be visible in the counter after the rising edge ending cycle N.
REQ-019 An edge-mode channel SHALL count events & ~prev, where prev is registered every cycle in every state; an event already high when start is applied SHALL NOT count as an edge.
REQ-020 The cycle counter SHALL increment by 1 on every RUN cycle, including the cycle in which stop is sampled.
REQ-021 A counter at all-ones that receives an increment SHALL wrap to 0 and set its ovf bit; the ovf bit SHALL remain set until clear or reset.
REQ-022 clear SHALL zero all counters, ovf bits and shadow registers in one cycle; an event in the clear cycle SHALL be discarded.
REQ-023 rd_data SHALL update one cycle after rd_sel is sampled; an rd_sel value greater than NUM_CH SHALL read 0.
REQ-024 Changing edge_mode while in RUN SHALL take effect on the next cycle, with no spurious increment.

Reset
REQ-025 While reset_n = 0 at a rising edge, the block SHALL set state = IDLE, all counters = 0, ovf = 0, shadow registers = 0, prev = 0 and rd_data = 0.
REQ-026 Reset asserted during RUN SHALL abort counting with no partial update and take priority over every other input.

Configuration
REQ-027 Macro PERF_SNAPSHOT_EN SHALL control the snapshot feature.
REQ-028 With PERF_SNAPSHOT_EN defined:
- snap SHALL copy every live counter into its shadow register at the edge.
- Entering FROZEN SHALL auto-capture the shadow registers with the final values.
- rd_data SHALL read the shadow registers.
- snap and clear asserted together SHALL leave the shadow registers at 0.
REQ-029 Without PERF_SNAPSHOT_EN, no shadow registers SHALL exist, snap SHALL be ignored, and rd_data SHALL read the live counters.

Structure
REQ-030 Package perf_pkg SHALL hold the FSM state typedef (IDLE = 0, RUN = 1, FROZEN = 2) and the constants MODE_LEVEL = 0 and MODE_EDGE = 1.
REQ-031 Sub-module perf_chan_cnt SHALL implement one channel: prev register, edge/level select, CNT_W counter and sticky overflow bit.
REQ-032 perf_chan_cnt SHALL be instantiated NUM_CH+1 times; the cycle-counter instance has its event tied to 1 and its mode set to level.

Verification
REQ-033 Scenario, level mode: NUM_CH = 4; start; hold events[0] high for 10 cycles; stop; rd_sel = 0 -> rd_data = 10; rd_sel = 4 -> rd_data equals RUN cycles (at least 10).
REQ-034 Scenario, edge mode: edge_mode[1] = 1; events[1] high before start and kept high 5 cycles, then toggled 3 times -> count = 3.
REQ-035 Scenario, wrap: CNT_W = 8; 257 level events -> count = 1 and ovf[0] = 1; then clear -> count = 0, ovf = 0, state = IDLE.
REQ-036 Scenario, priority: start and stop in the same RUN cycle -> FROZEN; clear and stop together -> IDLE with zeroed counters.
REQ-037 Scenario, snapshot (PERF_SNAPSHOT_EN): snap at count 7, then 5 more events -> rd_data = 7; stop -> rd_data = 12.
REQ-038 Scenario, reset: reset_n low mid-RUN with 20 counted -> next cycle state = IDLE and rd_data = 0 for every rd_sel.

Source files
------------

// File: rtl/perf_pkg.sv
// perf_pkg: FSM state type and channel mode constants shared by perf_counters and perf_chan_cnt
package perf_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FROZEN = 2'd2} state_t;
  localparam logic MODE_LEVEL = 1'b0;
  localparam logic MODE_EDGE = 1'b1;
endpackage

// File: rtl/perf_chan_cnt.sv
// perf_chan_cnt: one event channel (prev register, edge/level select, wrapping counter, sticky ovf); cnt_nxt is the post-edge value
module perf_chan_cnt
  import perf_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic             clr,
  input  logic             evt,
  input  logic             mode,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_nxt,
  output logic             ovf
);
  logic prev_q, inc, ovf_d, ovf_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  always_comb begin
    inc = run && !clr && (mode == MODE_EDGE ? evt && !prev_q : evt);
    cnt_d = clr ? '0 : cnt_q + CNT_W'(inc);
    ovf_d = !clr && (ovf_q || (inc && &cnt_q));
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev_q <= 1'b0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      prev_q <= evt;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end
  assign cnt = cnt_q;
  assign cnt_nxt = cnt_d;
  assign ovf = ovf_q;
endmodule

// File: rtl/perf_counters.sv
// perf_counters: NUM_CH event counters plus a cycle counter under an IDLE/RUN/FROZEN FSM with registered readout; PERF_SNAPSHOT_EN adds shadow registers
module perf_counters
  import perf_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int CNT_W = 32
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_CH-1:0]            events,
  input  logic [NUM_CH-1:0]            edge_mode,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         clear,
  input  logic                         snap,
  input  logic [$clog2(NUM_CH+1)-1:0]  rd_sel,
  output logic [CNT_W-1:0]             rd_data,
  output logic [NUM_CH:0]              ovf,
  output logic [1:0]                   state
);
  localparam int SEL_W = $clog2(NUM_CH + 1);
  state_t state_q, state_d;
  logic [NUM_CH:0] evt_all, mode_all;
  logic [NUM_CH:0][CNT_W-1:0] cnt, cnt_nxt, src;
  logic [CNT_W-1:0] rd_data_d, rd_data_q;
  assign evt_all = {1'b1, events};
  assign mode_all = {MODE_LEVEL, edge_mode};
  always_comb begin
    state_d = clear ? IDLE : stop ? (state_q == RUN ? FROZEN : state_q) : (start && state_q != RUN) ? RUN : state_q;
  end
  for (genvar c = 0; c <= NUM_CH; c++) begin : g_chan
    perf_chan_cnt #(.CNT_W(CNT_W)) u_chan (
      .clk(clk),
      .reset_n(reset_n),
      .run(state_q == RUN),
      .clr(clear),
      .evt(evt_all[c]),
      .mode(mode_all[c]),
      .cnt(cnt[c]),
      .cnt_nxt(cnt_nxt[c]),
      .ovf(ovf[c])
    );
  end
`ifdef PERF_SNAPSHOT_EN
  logic [NUM_CH:0][CNT_W-1:0] shadow_d, shadow_q;
  always_comb begin
    shadow_d = clear ? '0 : (snap || (state_q == RUN && state_d == FROZEN)) ? cnt_nxt : shadow_q;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) shadow_q <= '0;
    else shadow_q <= shadow_d;
  end
  assign src = shadow_q;
`else
  logic unused_snap;
  assign unused_snap = snap ^ (^cnt_nxt);
  assign src = cnt;
`endif
  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i <= NUM_CH; i++) rd_data_d = (rd_sel == SEL_W'(i)) ? src[i] : rd_data_d;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rd_data_q <= '0;
    end else begin
      state_q <= state_d;
      rd_data_q <= rd_data_d;
    end
  end
  assign rd_data = rd_data_q;
  assign state = state_q;
endmodule

// File: tb/tb_perf_counters.sv
// tb_perf_counters: directed scenarios plus random stimulus against a per-cycle behavioural model of perf_counters
module tb_perf_counters;
  localparam int N = 4;
  localparam int W = 8;
  localparam int SW = $clog2(N + 1);
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0, snap = 1'b0;
  logic [N-1:0] events = '0, edge_mode = '0;
  logic [SW-1:0] rd_sel = '0;
  logic [W-1:0] rd_data;
  logic [N:0] ovf;
  logic [1:0] state;
  int errors = 0, checks = 0;
  int unsigned m_cnt[N+1], m_shd[N+1], m_rd;
  bit m_ovf[N+1];
  bit [N-1:0] m_prev;
  int m_st;
  always #5 clk = ~clk;
  perf_counters #(.NUM_CH(N), .CNT_W(W)) dut (
    .clk(clk), .reset_n(reset_n), .events(events), .edge_mode(edge_mode),
    .start(start), .stop(stop), .clear(clear), .snap(snap), .rd_sel(rd_sel),
    .rd_data(rd_data), .ovf(ovf), .state(state)
  );
  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic void model();
    int old_st = m_st;
    bit hit;
    if (!reset_n) begin
      for (int i = 0; i <= N; i++) begin
        m_cnt[i] = 0;
        m_shd[i] = 0;
        m_ovf[i] = 0;
      end
      m_prev = '0;
      m_st = 0;
      m_rd = 0;
      return;
    end
`ifdef PERF_SNAPSHOT_EN
    m_rd = (rd_sel <= N) ? m_shd[rd_sel] : 0;
`else
    m_rd = (rd_sel <= N) ? m_cnt[rd_sel] : 0;
`endif
    if (m_st == 1 && !clear)
      for (int i = 0; i <= N; i++) begin
        hit = (i == N) ? 1'b1 : edge_mode[i] ? (events[i] && !m_prev[i]) : events[i];
        if (hit) begin
          m_cnt[i] = (m_cnt[i] + 1) % (1 << W);
          if (m_cnt[i] == 0) m_ovf[i] = 1;
        end
      end
    if (clear) m_st = 0;
    else if (stop) m_st = (m_st == 1) ? 2 : m_st;
    else if (start && m_st != 1) m_st = 1;
`ifdef PERF_SNAPSHOT_EN
    for (int i = 0; i <= N; i++)
      if (clear) m_shd[i] = 0;
      else if (snap || (old_st == 1 && m_st == 2)) m_shd[i] = m_cnt[i];
`endif
    if (clear)
      for (int i = 0; i <= N; i++) begin
        m_cnt[i] = 0;
        m_ovf[i] = 0;
      end
    m_prev = events;
  endfunction
  task automatic tick(input int n = 1);
    logic [N:0] eo;
    for (int k = 0; k < n; k++) begin
      model();
      @(posedge clk);
      #1;
      for (int i = 0; i <= N; i++) eo[i] = m_ovf[i];
      check("state", state, m_st);
      check("ovf", ovf, eo);
      check("rd_data", rd_data, m_rd);
    end
  endtask
  initial begin
    tick(2);
    check("rst_state", state, 0);
    check("rst_rd", rd_data, 0);
    reset_n = 1'b1;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    events[0] = 1'b1; tick(10); events[0] = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;
    rd_sel = 0; tick();
    check("lvl_cnt", rd_data, 10);
    rd_sel = 4; tick();
    check("lvl_cyc", rd_data, 11);
    clear = 1'b1; tick(); clear = 1'b0;
    edge_mode[1] = 1'b1;
    events[1] = 1'b1; tick(2);
    start = 1'b1; tick(); start = 1'b0;
    tick(5);
    for (int t = 0; t < 3; t++) begin
      events[1] = 1'b0; tick();
      events[1] = 1'b1; tick();
    end
    events[1] = 1'b0; tick();
    stop = 1'b1; tick(); stop = 1'b0;
    rd_sel = 1; tick();
    check("edge_cnt", rd_data, 3);
    edge_mode = '0;
    clear = 1'b1; tick(); clear = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    events[0] = 1'b1; tick(257); events[0] = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;
    rd_sel = 0; tick();
    check("wrap_cnt", rd_data, 1);
    check("wrap_ovf", ovf[0], 1);
    clear = 1'b1; tick(); clear = 1'b0;
    check("clr_state", state, 0);
    check("clr_ovf", ovf, 0);
    tick();
    check("clr_cnt", rd_data, 0);
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    check("idle_ss", state, 0);
    start = 1'b1; tick();
    stop = 1'b1; tick(); stop = 1'b0;
    check("run_ss", state, 2);
    tick();
    check("resume", state, 1);
    start = 1'b0; events[2] = 1'b1;
    clear = 1'b1; stop = 1'b1; tick(); clear = 1'b0; stop = 1'b0;
    check("clr_stop", state, 0);
    rd_sel = 2; tick(2);
    check("clr_stop_cnt", rd_data, 0);
    events[2] = 1'b0;
`ifdef PERF_SNAPSHOT_EN
    start = 1'b1; tick(); start = 1'b0;
    events[0] = 1'b1; tick(7); events[0] = 1'b0;
    snap = 1'b1; tick(); snap = 1'b0;
    events[0] = 1'b1; tick(5); events[0] = 1'b0;
    rd_sel = 0; tick();
    check("snap_hold", rd_data, 7);
    stop = 1'b1; tick(); stop = 1'b0;
    tick();
    check("snap_frz", rd_data, 12);
    clear = 1'b1; snap = 1'b1; tick(); clear = 1'b0; snap = 1'b0;
    tick();
    check("snap_clr", rd_data, 0);
`endif
    clear = 1'b1; tick(); clear = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    events[0] = 1'b1; tick(20);
    reset_n = 1'b0; start = 1'b1; tick(); start = 1'b0;
    check("rst_run_state", state, 0);
    check("rst_run_rd", rd_data, 0);
    reset_n = 1'b1; events = '0;
    for (int s = 0; s < 8; s++) begin
      rd_sel = SW'(s); tick();
      check("rst_sel", rd_data, 0);
    end
    for (int k = 0; k < 600; k++) begin
      events = N'($urandom);
      if ($urandom_range(0, 19) == 0) edge_mode = N'($urandom);
      start = ($urandom_range(0, 9) == 0);
      stop = ($urandom_range(0, 14) == 0);
      clear = ($urandom_range(0, 39) == 0);
      snap = ($urandom_range(0, 9) == 0);
      reset_n = ($urandom_range(0, 99) != 0);
      rd_sel = SW'($urandom_range(0, 7));
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
